multi_cycle_ctrl: RTL
=====================

// Module: multi_cycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath. Decodes opcode/funct and sequences IF/ID/EX/MEM/WB,
//  driving the mux selects, write enables and ALU op each cycle. Waits on the shared memory's ready handshake.
//  Supports free-run and single-step operation from board switches/buttons; counts retired instructions.
// PARAMETERS
//  CNT_W   16  width of retired-instruction counter (wraps)
// PORTS
//  clk_100mhz   in   1   system clock, all state on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  opcode       in   6   IR[31:26]
//  funct        in   6   IR[5:0]
//  zero         in   1   ALU zero flag
//  mem_ready    in   1   memory access complete this cycle
//  run          in   1   level: 1 = free-run
//  step         in   1   1-cycle pulse: execute one instruction from IDLE
//  pc_write     out  1   PC load enable
//  iord         out  1   mem addr select: 0 PC, 1 ALUOut
//  mem_read / mem_write  out 1 each  memory strobes, held until mem_ready
//  ir_write     out  1   IR/MDR load
//  reg_dst      out  1   0 rt, 1 rd
//  mem_to_reg   out  1   0 ALUOut, 1 MDR
//  reg_write    out  1   register file write enable
//  alu_src_a    out  1   0 PC, 1 A
//  alu_src_b    out  2   00 B, 01 const 4, 10 ext imm, 11 sext imm<<2
//  ext_zero     out  1   1 zero-extend imm (andi/ori)
//  alu_ctrl     out  4   0000 AND,0001 OR,0010 ADD,0110 SUB,0111 SLT,1100 NOR
//  pc_source    out  2   00 ALU result, 01 ALUOut, 10 jump target
//  instr_done   out  1   1-cycle pulse on last cycle of each instruction
//  illegal      out  1   sticky: undecodable instruction seen
//  state        out  4   current state, for 7-seg debug
//  instr_cnt    out  CNT_W  retired instructions
// BEHAVIOUR
//  - Reset: state=IDLE, illegal=0, instr_cnt=0. All controls decode from state (+mem_ready/zero), so all are 0 in IDLE.
//  - States: IDLE0 IF1 ID2 MA3 MR4 MWB5 MW6 RX7 RWB8 BR9 JMP10 IX11 IWB12.
//  - IDLE: all 0; ->IF if !illegal && (run||step).
//  - IF: mem_read=1, iord=0, src_a=0, src_b=01, ADD. Stay until mem_ready.
//    When mem_ready=1, same cycle: ir_write=1, pc_write=1, pc_source=00; ->ID.
//  - ID: src_a=0, src_b=11, ADD (branch target to ALUOut). Dispatch:
//    lw23/sw2B->MA; R00->RX; beq04/bne05->BR; j02->JMP; addi08/andi0C/ori0D/slti0A->IX.
//    Any other opcode or R funct not in {20,22,24,25,27,2A}: set illegal, ->IDLE, no instr_done.
//  - MA: src_a=1, src_b=10, ADD; lw->MR, sw->MW.
//  - MR: iord=1, mem_read=1; on mem_ready: ir_write=0, ->MWB (MDR latches every cycle externally).
//  - MWB: reg_dst=0, mem_to_reg=1, reg_write=1. Done.
//  - MW: iord=1, mem_write=1; done on mem_ready.
//  - RX: src_a=1, src_b=00, alu_ctrl from funct (add ADD, sub SUB, and, or, nor, slt). ->RWB.
//  - RWB: reg_dst=1, reg_write=1. Done.
//  - BR: src_a=1, src_b=00, SUB, pc_source=01; pc_write=zero (beq) / ~zero (bne). Done.
//  - JMP: pc_source=10, pc_write=1. Done.
//  - IX: src_a=1, src_b=10; addi ADD, andi AND+ext_zero, ori OR+ext_zero, slti SLT. ->IWB.
//  - IWB: reg_dst=0, mem_to_reg=0, reg_write=1. Done.
//  - Done: instr_done=1 that cycle; instr_cnt+=1 (wraps to 0 at max); next = run ? IF : IDLE.
//  - Latency with mem_ready=1 every request:
//    beq/bne/j 3, R/I/sw 4, lw 5 cycles.
//  - step outside IDLE ignored. run falling mid-instruction: finish it, then IDLE.
//  - mem_ready outside IF/MR/MW ignored. Reset mid-instruction: immediate IDLE, strobes drop asynchronously.
//  - illegal held until reset; IDLE is then absorbing.
// STRUCTURE
//  - Header multi_cycle_defs.vh: state codes, opcode/funct codes, alu_ctrl and alu_src_b/pc_source encodings.
//    Shared with datapath and bench.
//  - Sub-module alu_ctrl_dec: combinational funct/opcode -> alu_ctrl, ext_zero, legal flag.
//  - Main: state register, next-state logic, output decode, counter, sticky flag.
// TESTING
//  - Reset with run=1 held: stays IDLE while rst_n=0, all outputs 0; first edge after release -> IF.
//  - run=1, mem_ready=1, IR add (00/20): states 1,2,7,8.
//    RWB has reg_write=1, reg_dst=1, alu_ctrl 0010 in RX; instr_done at cycle 4, instr_cnt=1.
//  - lw (23) with mem_ready low 3 cycles in MR: MR holds 4 cycles with mem_read=1, iord=1; then MWB reg_write=1, mem_to_reg=1.
//  - beq zero=1 -> pc_write=1, pc_source=01 in BR.
//    beq zero=0 -> pc_write=0. bne inverts both cases.
//  - run=0, step pulse: one sw (2B) executes then IDLE. Second step while in MW is ignored; instr_cnt +1 only.
//  - opcode 3F: illegal=1, IDLE, no instr_done.
//    Further step/run ignored until rst_n pulse clears illegal.
//  - Counter wrap: with CNT_W=4, 16 j instructions -> instr_cnt returns to 0.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, opcode/funct
// codes, ALU operations and datapath mux selects.
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_IF   = 4'd1,
    S_ID   = 4'd2,
    S_MA   = 4'd3,
    S_MR   = 4'd4,
    S_MWB  = 4'd5,
    S_MW   = 4'd6,
    S_RX   = 4'd7,
    S_RWB  = 4'd8,
    S_BR   = 4'd9,
    S_JMP  = 4'd10,
    S_IX   = 4'd11,
    S_IWB  = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl_alu_ctrl_dec.sv
// Combinational instruction decoder: ALU operation, immediate extension mode and
// whether the opcode/funct pair is an instruction this controller can execute.
module alu_ctrl_dec
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       ext_zero_o,
  output logic       legal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    ext_zero_o = 1'b0;
    legal_o    = 1'b1;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: legal_o    = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: alu_ctrl_o = ALU_ADD;
      OP_ANDI: begin
        alu_ctrl_o = ALU_AND;
        ext_zero_o = 1'b1;
      end
      OP_ORI: begin
        alu_ctrl_o = ALU_OR;
        ext_zero_o = 1'b1;
      end
      OP_SLTI: alu_ctrl_o = ALU_SLT;
      default: legal_o    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: sequences fetch/decode/execute,
// handshakes with shared memory, counts retired instructions, flags illegal opcodes.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_100mhz,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             run,
  input  logic             step,
  output logic             pc_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       decAluCtrl;
  logic             decExtZero;
  logic             decLegal;

  alu_ctrl_dec u_dec (
    .opcode_i  (opcode),
    .funct_i   (funct),
    .alu_ctrl_o(decAluCtrl),
    .ext_zero_o(decExtZero),
    .legal_o   (decLegal)
  );

  // Controls are a pure decode of the state register so they fall with reset.
  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    ext_zero   = 1'b0;
    alu_ctrl   = ALU_AND;
    pc_source  = PCSRC_ALU;
    instr_done = 1'b0;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID: begin
        alu_src_b = SRCB_BOFS;
        alu_ctrl  = ALU_ADD;
      end
      S_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
      end
      S_MR: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MW: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_RX: begin
        alu_src_a = 1'b1;
        alu_ctrl  = decAluCtrl;
      end
      S_RWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_source  = PCSRC_OUT;
        pc_write   = zero ^ (opcode == OP_BNE);
        instr_done = 1'b1;
      end
      S_JMP: begin
        pc_source  = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_IX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = decAluCtrl;
        ext_zero  = decExtZero;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Completion overrides the per-state successor: run decides fetch vs. idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!illegal_q && (run || step)) state_d = S_IF;
      S_IF:   if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (!decLegal)                               state_d = S_IDLE;
        else if (opcode == OP_LW || opcode == OP_SW) state_d = S_MA;
        else if (opcode == OP_RTYPE)                 state_d = S_RX;
        else if (opcode == OP_BEQ || opcode == OP_BNE) state_d = S_BR;
        else if (opcode == OP_J)                     state_d = S_JMP;
        else                                         state_d = S_IX;
      end
      S_MA:   state_d = (opcode == OP_LW) ? S_MR : S_MW;
      S_MR:   if (mem_ready) state_d = S_MWB;
      S_RX:   state_d = S_RWB;
      S_IX:   state_d = S_IWB;
      default: ;
    endcase
    if (instr_done) state_d = run ? S_IF : S_IDLE;
  end

  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID && !decLegal) illegal_q <= 1'b1;
      if (instr_done) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign state     = state_q;
  assign illegal   = illegal_q;
  assign instr_cnt = cnt_q;

endmodule
